fp_mul_seq_ctrl: RTL and testbench

- Sequential single-precision floating-point multiplier controller for the twiddle-multiply path of the radix-3^2 FFT.
- Accepts one operand pair per transaction on a valid/ready handshake and computes sign and biased exponent combinationally in a sub-module.
- Sequences a 24-iteration radix-2 shift-add mantissa multiply, then normalises and packs the result.
- Presents the result on an output valid/ready handshake with overflow/underflow flags. Trades throughput for area, since one instance is shared per butterfly stage.

---
 rtl/fp_mul_pkg.sv | 18 +
 rtl/fp_sign_exp_calc.sv | 25 ++
 rtl/fp_mul_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_fp_mul_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and default widths for the sequential FP32 twiddle multiplier.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    localparam int FP_EXP_W    = 8;
    localparam int FP_FRAC_W   = 23;
    localparam int FP_EXP_BIAS = 127;
    localparam int FP_EXP_INF  = (1 << FP_EXP_W) - 1;
    localparam int FP_MANT_W   = FP_FRAC_W + 1;
    localparam int FP_ACC_W    = 2 * FP_MANT_W;

endpackage

// File: rtl/fp_sign_exp_calc.sv
// Result sign, signed biased exponent sum and zero-operand detect for one operand pair.
module fp_sign_exp_calc
    import fp_mul_pkg::*;
#(
    parameter int EXP_W    = FP_EXP_W,
    parameter int EXP_BIAS = FP_EXP_BIAS
) (
    input  logic                    sa,
    input  logic                    sb,
    input  logic [EXP_W-1:0]        ea,
    input  logic [EXP_W-1:0]        eb,
    output logic                    sign,
    output logic signed [EXP_W+1:0] exp_sum,
    output logic                    zero
);

    localparam logic signed [EXP_W+1:0] BIAS = (EXP_W + 2)'(EXP_BIAS);

    assign sign    = sa ^ sb;
    // Two guard bits hold both 2*max-bias and negative underflow values.
    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    // Zero and denormal exponents both read as zero magnitude.
    assign zero    = (ea == '0) || (eb == '0);

endmodule

// File: rtl/fp_mul_seq_ctrl.sv
// Sequential FP32 multiplier: shift-add mantissa product, truncating normaliser, valid/ready I/O.
module fp_mul_seq_ctrl
    import fp_mul_pkg::*;
#(
    parameter int EXP_W    = FP_EXP_W,
    parameter int FRAC_W   = FP_FRAC_W,
    parameter int EXP_BIAS = FP_EXP_BIAS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   p,
    output logic                    ovf,
    output logic                    unf,
    output logic                    busy
);

    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int MANT_W = FRAC_W + 1;
    localparam int ACC_W  = 2 * MANT_W;
    localparam int CNT_W  = $clog2(MANT_W + 1);
    localparam int EW     = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_INF = EW'((1 << EXP_W) - 1);

    state_t state, state_nxt;

    logic                 sign_c, zero_c;
    logic signed [EW-1:0] exp_c;

    logic                 sign_r;
    logic signed [EW-1:0] exp_r;
    logic [MANT_W-1:0]    ma, mb;
    logic [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]     cnt;
    logic [W-1:0]         p_r;
    logic                 ovf_r, unf_r, out_valid_r;

    logic signed [EW-1:0] exp_n;
    logic [FRAC_W-1:0]    frac_n;
    logic                 accept;

    fp_sign_exp_calc #(
        .EXP_W    (EXP_W),
        .EXP_BIAS (EXP_BIAS)
    ) u_sign_exp (
        .sa      (a[W-1]),
        .sb      (b[W-1]),
        .ea      (a[W-2 -: EXP_W]),
        .eb      (b[W-2 -: EXP_W]),
        .sign    (sign_c),
        .exp_sum (exp_c),
        .zero    (zero_c)
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign p         = p_r;
    assign ovf       = ovf_r;
    assign unf       = unf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = zero_c ? DONE : MUL;
            MUL:     if (cnt == CNT_W'(FRAC_W)) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (out_valid_r && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Product of two 1.x mantissas lies in [1,4); bit ACC_W-1 marks the [2,4) case.
    always_comb begin
        exp_n  = exp_r;
        frac_n = acc[ACC_W-3 -: FRAC_W];
        if (acc[ACC_W-1]) begin
            exp_n  = exp_r + EW'(1);
            frac_n = acc[ACC_W-2 -: FRAC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r      <= 1'b0;
            exp_r       <= '0;
            ma          <= '0;
            mb          <= '0;
            acc         <= '0;
            cnt         <= '0;
            p_r         <= '0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_r <= sign_c;
                        exp_r  <= exp_c;
                        ma     <= {1'b1, a[FRAC_W-1:0]};
                        mb     <= {1'b1, b[FRAC_W-1:0]};
                        acc    <= '0;
                        cnt    <= '0;
                        if (zero_c) begin
                            p_r         <= {sign_c, {(W-1){1'b0}}};
                            ovf_r       <= 1'b0;
                            unf_r       <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mb[0]) acc <= acc + (ACC_W'(ma) << cnt);
                    mb  <= mb >> 1;
                    cnt <= cnt + CNT_W'(1);
                end
                NORM: begin
                    out_valid_r <= 1'b1;
                    if (exp_n >= EXP_INF) begin
                        p_r   <= {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        ovf_r <= 1'b1;
                        unf_r <= 1'b0;
                    end else if (exp_n <= EW'(0)) begin
                        p_r   <= {sign_r, {(W-1){1'b0}}};
                        ovf_r <= 1'b0;
                        unf_r <= 1'b1;
                    end else begin
                        p_r   <= {sign_r, exp_n[EXP_W-1:0], frac_n};
                        ovf_r <= 1'b0;
                        unf_r <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_valid_r && out_ready) out_valid_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Scoreboarded bench for fp_mul_seq_ctrl: results, flags, latency, backpressure and reset abort.
module tb_fp_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, ovf, unf, busy;
    logic [31:0] p;

    typedef struct {
        logic [31:0] p;
        logic        ovf;
        logic        unf;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int   cyc = 0;
    int   acc_cyc = 0;
    int   lat_obs = 0;
    bit   seen = 1'b0;

    fp_mul_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .ovf       (ovf),
        .unf       (unf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Monitor: pre-edge values give the handshakes that complete at this edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            cyc++;
            if (in_valid && in_ready) begin
                acc_cyc = cyc;
                seen    = 1'b0;
            end
            if (out_valid && !seen) begin
                seen    = 1'b1;
                lat_obs = cyc - acc_cyc;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_output p=%h (no expectation queued)", p);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    n_cmp++;
                    if (p !== e.p) begin
                        n_bad++;
                        $display("FAIL result_p got=%h want=%h", p, e.p);
                    end
                    n_cmp++;
                    if (ovf !== e.ovf) begin
                        n_bad++;
                        $display("FAIL result_ovf got=%b want=%b (p=%h)", ovf, e.ovf, e.p);
                    end
                    n_cmp++;
                    if (unf !== e.unf) begin
                        n_bad++;
                        $display("FAIL result_unf got=%b want=%b (p=%h)", unf, e.unf, e.p);
                    end
                    n_cmp++;
                    if (lat_obs !== e.lat) begin
                        n_bad++;
                        $display("FAIL latency got=%0d want=%0d (p=%h)", lat_obs, e.lat, e.p);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [31:0] ep, input logic eo, input logic eu, input int el);
        exp_t e;
        e.p = ep; e.ovf = eo; e.unf = eu; e.lat = el;
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [31:0] va, input logic [31:0] vb);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL in_ready_timeout got=%b want=1", in_ready);
        end
        a = va; b = vb; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (out_valid !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL out_valid_timeout got=%b want=1", out_valid);
        end
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_one(input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] ep, input logic eo, input logic eu, input int el);
        push_exp(ep, eo, eu, el);
        send(va, vb);
        wait_valid();
        take();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if ({p, ovf, unf, out_valid, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got p=%h ovf=%b unf=%b ov=%b busy=%b want all 0",
                     p, ovf, unf, out_valid, busy);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        run_one(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 26);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL after_take got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        run_one(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, 26);
        run_one(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 26);
        run_one(32'hC0000000, 32'h3F000000, 32'hBF800000, 1'b0, 1'b0, 26);
    endtask

    task automatic test_zero();
        run_one(32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 1);
        run_one(32'h00000000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 1);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_ovf_unf();
        run_one(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 26);
        run_one(32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 26);
        run_one(32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0, 26);
    endtask

    task automatic test_back_to_back();
        push_exp(32'h40400000, 1'b0, 1'b0, 26);
        send(32'h3FC00000, 32'h40000000);
        wait_valid();
        @(negedge clk);
        a = 32'h40000000; b = 32'h40400000; in_valid = 1'b1;
        push_exp(32'h40C00000, 1'b0, 1'b0, 26);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (p !== 32'h40400000 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_stable cyc%0d got p=%h in_ready=%b ov=%b want 40400000/0/1",
                         i, p, in_ready, out_valid);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL next_accept got busy=%b want=1", busy);
        end
        wait_valid();
        take();
    endtask

    task automatic test_reset_mid();
        send(32'h3FC00000, 32'h40000000);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({p, ovf, unf, out_valid, busy} !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset got p=%h ovf=%b unf=%b ov=%b busy=%b in_ready=%b want 0s/ready",
                     p, ovf, unf, out_valid, busy, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_one(32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, 26);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero();
        test_ovf_unf();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
